alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter RR_INIT, default 0, which sets which requester holds priority after reset (0 or 1).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port req_valid, input, 2 bits: bit i set means requester i presents an operation.
REQ-005 The block SHALL have port req_ready, output, 2 bits: bit i set means requester i's operation is accepted this cycle.
REQ-006 The block SHALL have port req_a, input, 8 bits: operand A; bits [4i+3:4i] belong to requester i.
REQ-007 The block SHALL have port req_b, input, 8 bits: operand B, packed the same way as req_a.
REQ-008 The block SHALL have port req_op, input, 6 bits: opcode; bits [3i+2:3i] belong to requester i.
REQ-009 The block SHALL have port rsp_valid, output, 1 bit: the response fields are valid.
REQ-010 The block SHALL have port rsp_ready, input, 1 bit: the consumer accepts the response.
REQ-011 The block SHALL have port rsp_id, output, 1 bit: the requester that owns the response.
REQ-012 The block SHALL have port rsp_result, output, 4 bits: the registered ALU result.
REQ-013 The block SHALL have port rsp_carry, output, 1 bit: the registered carry/borrow flag.
REQ-014 The block SHALL have port rsp_zero, output, 1 bit: the registered zero flag, set when rsp_result == 0.

Function
REQ-015 The opcodes SHALL be: 000 A+B; 001 A-B; 010 A&B; 011 A|B; 100 A^B; 101-111 result 0.
REQ-016 For 000 and 001, {carry,result} SHALL be the 5-bit sum or difference; for 001, carry=1 exactly when A<B (borrow); all other opcodes give carry=0.
REQ-017 The FSM SHALL have states IDLE and HOLD.
REQ-018 In IDLE, req_ready SHALL be one-hot on the granted valid requester, or 0 when none is valid.
REQ-019 Transfer from requester i SHALL occur on a cycle where req_valid[i] && req_ready[i].
REQ-020 On transfer, the FSM SHALL go to HOLD at the next edge with the result, flags and id registered (latency 1); rsp_valid=1 in HOLD.
REQ-021 In HOLD, req_ready SHALL be 0 and the response outputs SHALL stay stable until rsp_valid && rsp_ready.
REQ-022 From HOLD, rsp_valid && rsp_ready SHALL return the FSM to IDLE; no new grant is given in that same cycle, so throughput is at most one operation per 2 cycles.
REQ-023 Arbitration SHALL be round-robin: with both requesters valid, grant the one not granted last; with one valid, grant it regardless of pointer.
REQ-024 The priority pointer SHALL update only on a transfer.
REQ-025 The grant SHALL be a combinational function of req_valid and the pointer; the datapath SHALL be muxed by the grant.
REQ-026 Requests withdrawn before transfer SHALL have no effect; the FSM and pointer stay unchanged.

Reset
REQ-027 While rst_n=0, the block SHALL be in IDLE with req_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_carry=0, rsp_zero=0, and the pointer set so requester RR_INIT wins the first tie.
REQ-028 Reset asserted in HOLD SHALL discard the pending response immediately, without waiting for a clock.

Configuration
REQ-029 With macro ALU_ARBITER_OPCNT_EN defined, the block SHALL add output op_count, 8 bits, counting completed responses (rsp_valid && rsp_ready), reset 0, wrapping 255->0.
REQ-030 Without ALU_ARBITER_OPCNT_EN, the port and counter SHALL be absent, with otherwise identical behaviour.

Structure
REQ-031 A shared package alu_pkg SHALL hold the opcode constants (OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR), the FSM state typedef, and the 4-bit data width constant.
REQ-032 A sub-module alu_rr_arb SHALL implement the 2-way round-robin grant and pointer; the ALU datapath and FSM SHALL stay in alu_arbiter.

Verification
REQ-033 The bench SHALL check: req0 only, A=7, B=9, op 000, rsp_ready=1 -> next cycle rsp_valid=1, id=0, result=0, carry=1, zero=1.
REQ-034 The bench SHALL check: req1 only, A=3, B=5, op 001 -> result=14 (0xE), carry=1, zero=0; with A=5, B=3 -> result=2, carry=0.
REQ-035 The bench SHALL check: both valid continuously after reset with RR_INIT=0, rsp_ready=1 -> rsp_id sequence 0,1,0,1 with one response every 2 cycles.
REQ-036 The bench SHALL check: rsp_ready held 0 for 5 cycles in HOLD -> outputs stable and req_ready=0 throughout; the response is accepted on the cycle rsp_ready rises.
REQ-037 The bench SHALL check: rst_n dropped mid-HOLD between clock edges -> rsp_valid=0 immediately; after release a tie is granted to RR_INIT.
REQ-038 The bench SHALL check: op 110, A=F, B=F -> result=0, carry=0, zero=1; with ALU_ARBITER_OPCNT_EN defined, 256 completions -> op_count=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter: data width, opcodes,
// FSM state type, request/response records and the ALU evaluation function.
package alu_pkg;

  localparam int DW   = 4;
  localparam int NREQ = 2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  typedef struct packed {
    logic [2:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } alu_req_t;

  typedef struct packed {
    logic          id;
    logic [DW-1:0] result;
    logic          carry;
    logic          zero;
  } alu_rsp_t;

  // Returns {carry, result}; the subtract carry is the borrow out of the 5-bit difference.
  function automatic logic [DW:0] alu_eval(input alu_req_t r);
    logic [DW:0] res;
    res = '0;
    case (r.op)
      OP_ADD:  res = {1'b0, r.a} + {1'b0, r.b};
      OP_SUB:  res = {1'b0, r.a} - {1'b0, r.b};
      OP_AND:  res = {1'b0, r.a & r.b};
      OP_OR:   res = {1'b0, r.a | r.b};
      OP_XOR:  res = {1'b0, r.a ^ r.b};
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_rr_arb.sv
// Two-way round-robin arbiter. Grant is combinational from req_valid and the
// priority pointer; the pointer moves only when a grant is issued (a grant in
// this block always coincides with a transfer since grant implies valid).
module alu_rr_arb
  import alu_pkg::*;
#(
  parameter int RR_INIT = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] grant
);

  // prio names the requester that wins a tie
  logic prio;

  // Pointer: after granting i, the other requester wins the next tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      prio <= RR_INIT[0];
    else if (|grant) prio <= grant[0];
  end

  // Grant: tie resolved by pointer, single requester granted unconditionally
  always_comb begin
    grant = '0;
    if (en) begin
      if (&req_valid) grant = prio ? 2'b10 : 2'b01;
      else            grant = req_valid;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two requesters share one 4-bit ALU. One operation is accepted in IDLE, its
// registered result is held in HOLD until the consumer takes it.
// Optional feature: define ALU_ARBITER_OPCNT_EN to add the 8-bit op_count
// output counting completed responses.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int RR_INIT = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*DW-1:0]   req_a,
  input  logic [NREQ*DW-1:0]   req_b,
  input  logic [NREQ*3-1:0]    req_op,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [DW-1:0]        rsp_result,
  output logic                 rsp_carry,
`ifdef ALU_ARBITER_OPCNT_EN
  output logic [7:0]           op_count,
`endif
  output logic                 rsp_zero
);

  state_t                 state, state_nx;
  alu_req_t [NREQ-1:0]    lane_req;
  logic     [NREQ-1:0]    grant;
  logic                   xfer;
  logic                   sel_id;
  logic     [DW:0]        alu_out;
  alu_rsp_t               rsp_q;

  // Unpack the per-requester operand fields into lane records
  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign lane_req[i] = '{op: req_op[3*i +: 3], a: req_a[DW*i +: DW], b: req_b[DW*i +: DW]};
  end

  // Arbitration is only offered in IDLE and out of reset, so req_ready is 0 while rst_n is low
  alu_rr_arb #(.RR_INIT(RR_INIT)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (rst_n && (state == IDLE)),
    .req_valid (req_valid),
    .grant     (grant)
  );

  assign req_ready = grant;
  assign xfer      = |(req_valid & grant);
  assign sel_id    = grant[1];
  assign alu_out   = alu_eval(lane_req[sel_id]);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state: accept in IDLE, release on consumer handshake (no same-cycle regrant)
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (xfer)      state_nx = HOLD;
      HOLD:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Response register: captured on transfer, frozen through HOLD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsp_q <= '0;
    else if (xfer) begin
      rsp_q.id     <= sel_id;
      rsp_q.result <= alu_out[DW-1:0];
      rsp_q.carry  <= alu_out[DW];
      rsp_q.zero   <= (alu_out[DW-1:0] == '0);
    end
  end

  assign rsp_valid  = (state == HOLD);
  assign rsp_id     = rsp_q.id;
  assign rsp_result = rsp_q.result;
  assign rsp_carry  = rsp_q.carry;
  assign rsp_zero   = rsp_q.zero;

`ifdef ALU_ARBITER_OPCNT_EN
  // Completed-response counter, wraps naturally at 8 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  op_count <= '0;
    else if (rsp_valid && rsp_ready) op_count <= op_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table plus hand-written
// sequences for round-robin, HOLD back-pressure, async reset and op_count.
module tb_alu_arbiter;

  logic       clk;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [7:0] req_a, req_b;
  logic [5:0] req_op;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_zero;
  logic [3:0] rsp_result;
`ifdef ALU_ARBITER_OPCNT_EN
  logic [7:0] op_count;
`endif

  alu_arbiter #(.RR_INIT(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
`ifdef ALU_ARBITER_OPCNT_EN
    .op_count   (op_count),
`endif
    .rsp_zero   (rsp_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       id;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic [3:0] er;
    logic       ec;
    logic       ez;
  } vec_t;

  typedef struct {
    logic       id;
    logic [3:0] result;
    logic       carry;
    logic       zero;
  } exp_t;

  vec_t vecs[10];
  exp_t sb[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive requester id with the given fields; the other lane carries junk
  task automatic drive_req(input logic id, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    req_a     = id ? {a, ~a} : {~a, a};
    req_b     = id ? {b, ~b} : {~b, b};
    req_op    = id ? {op, ~op} : {~op, op};
    req_valid = id ? 2'b10 : 2'b01;
  endtask

  task automatic pop_chk(input string nm);
    if (sb.size() == 0) begin
      chk({nm, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk({nm, "_id"},     rsp_id,     e.id);
      chk({nm, "_result"}, rsp_result, e.result);
      chk({nm, "_carry"},  rsp_carry,  e.carry);
      chk({nm, "_zero"},   rsp_zero,   e.zero);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    //                id    a      b      op      er     ec    ez
    vecs[0] = '{1'b0, 4'h7, 4'h9, 3'b000, 4'h0, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 4'h3, 4'h5, 3'b001, 4'hE, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 4'h5, 4'h3, 3'b001, 4'h2, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 4'hF, 4'hF, 3'b110, 4'h0, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 4'hC, 4'hA, 3'b010, 4'h8, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 4'h5, 4'hA, 3'b011, 4'hF, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 4'hF, 4'hF, 3'b100, 4'h0, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 4'h8, 4'h7, 3'b000, 4'hF, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 4'h3, 4'h4, 3'b101, 4'h0, 1'b0, 1'b1};
    vecs[9] = '{1'b1, 4'h6, 4'h6, 3'b001, 4'h0, 1'b0, 1'b1};

    // Reset state, with both requesters asserting
    rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 1'b1;
    req_a = 8'h00; req_b = 8'h00; req_op = 6'h00;
    repeat (2) @(negedge clk);
    chk("rst_req_ready",  req_ready,  2'b00);
    chk("rst_rsp_valid",  rsp_valid,  0);
    chk("rst_rsp_id",     rsp_id,     0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_carry",  rsp_carry,  0);
    chk("rst_rsp_zero",   rsp_zero,   0);
    req_valid = 2'b00;
    rst_n = 1'b1;

    // Table: one operation each, latency 1, consumer always ready
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive_req(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op);
      rsp_ready = 1'b1;
      sb.push_back('{vecs[i].id, vecs[i].er, vecs[i].ec, vecs[i].ez});
      #1;
      chk($sformatf("v%0d_req_ready", i), req_ready, vecs[i].id ? 2'b10 : 2'b01);
      @(posedge clk); #1;
      req_valid = 2'b00;
      chk($sformatf("v%0d_rsp_valid", i), rsp_valid, 1);
      pop_chk($sformatf("v%0d", i));
      @(posedge clk); #1;
      chk($sformatf("v%0d_released", i), rsp_valid, 0);
    end

    // Round-robin: both valid from reset, ids 0,1,0,1 one response per 2 cycles
    do_reset();
    @(negedge clk);
    req_a = {4'h2, 4'h1}; req_b = {4'h2, 4'h1}; req_op = 6'b000_000;
    req_valid = 2'b11; rsp_ready = 1'b1;
    sb.push_back('{1'b0, 4'h2, 1'b0, 1'b0});
    sb.push_back('{1'b1, 4'h4, 1'b0, 1'b0});
    sb.push_back('{1'b0, 4'h2, 1'b0, 1'b0});
    sb.push_back('{1'b1, 4'h4, 1'b0, 1'b0});
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk($sformatf("rr%0d_valid", k), rsp_valid, (k % 2 == 0));
      if (rsp_valid) pop_chk($sformatf("rr%0d", k));
    end
    req_valid = 2'b00;
    chk("rr_sb_drained", sb.size(), 0);

    // Back-pressure: 5 cycles in HOLD with rsp_ready low, other requester waiting
    @(negedge clk);
    drive_req(1'b0, 4'h3, 4'h4, 3'b000);
    req_valid = 2'b11;
    rsp_ready = 1'b0;
    sb.push_back('{1'b0, 4'h7, 1'b0, 1'b0});
    @(posedge clk); #1;
    e = sb.pop_front();
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("hold%0d_valid", c),  rsp_valid,  1);
      chk($sformatf("hold%0d_ready", c),  req_ready,  2'b00);
      chk($sformatf("hold%0d_result", c), rsp_result, e.result);
      chk($sformatf("hold%0d_id", c),     rsp_id,     e.id);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("hold_still_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    chk("hold_accepted", rsp_valid, 0);

    // Async reset in HOLD; last transfer was requester 0, RR_INIT must win the tie after reset
    @(negedge clk);
    drive_req(1'b0, 4'h9, 4'h3, 3'b001);
    rsp_ready = 1'b0;
    @(posedge clk); #3;
    chk("arst_pre_valid",  rsp_valid,  1);
    chk("arst_pre_result", rsp_result, 4'h6);
    rst_n = 1'b0;
    #1;
    chk("arst_valid",  rsp_valid,  0);
    chk("arst_result", rsp_result, 0);
    chk("arst_ready",  req_ready,  2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 2'b11;
    #1;
    chk("arst_tie_grant", req_ready, 2'b01);
    @(posedge clk); #1;
    chk("arst_tie_id", rsp_id, 0);
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    @(posedge clk); #1;

`ifdef ALU_ARBITER_OPCNT_EN
    do_reset();
    #1;
    chk("cnt_reset", op_count, 0);
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      drive_req(i[0], 4'h1, 4'h1, 3'b000);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      req_valid = 2'b00;
      @(posedge clk); #1;
      if (i == 0 || i == 254 || i == 255)
        chk($sformatf("cnt_after_%0d", i + 1), op_count, (i + 1) % 256);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
